// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-stage program counter and next-PC selection.
// Shares one external 32-bit adder between PC+PC_STEP in FETCH and the
// branch-target sum (base + offset<<2) in the one-cycle BR_CALC state.
// Optional macro PC_ALIGN_CHECK_EN: flags misaligned loaded PCs on a sticky
// addr_err and forces the low two pc bits to zero.
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] PC_STEP      = 32'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        br_valid,
  input  logic        br_taken,
  input  logic [31:0] br_base,
  input  logic [31:0] br_offset,
  input  logic        jmp_valid,
  input  logic [25:0] jmp_target,
  output logic [31:0] adder_a,
  output logic [31:0] adder_b,
  input  logic [31:0] adder_sum,
  output logic [31:0] pc,
  output logic        pc_valid,
  output logic        flush,
  output logic        busy,
  output logic        addr_err
);

  typedef enum logic [1:0] {
    FETCH   = 2'b00,
    BR_CALC = 2'b01
  } state_t;

`ifdef PC_ALIGN_CHECK_EN
  localparam logic [31:0] RESET_PC = {RESET_VECTOR[31:2], 2'b00};
`else
  localparam logic [31:0] RESET_PC = RESET_VECTOR;
`endif

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_pc;
  logic [31:0] w_pc_next;
  logic [31:0] r_br_base;
  logic [31:0] r_br_offset_sh;   // offset already shifted left by two
  logic [31:0] w_sum_load;       // adder result as it would be written to pc
  logic        w_load_sum;       // this cycle loads pc from the adder
  logic        w_capture;        // taken branch accepted in FETCH

`ifdef PC_ALIGN_CHECK_EN
  assign w_sum_load = {adder_sum[31:2], 2'b00};
`else
  assign w_sum_load = adder_sum;
`endif

  // Next-state, next-pc and all combinational outputs.
  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_capture    = 1'b0;
    w_load_sum   = 1'b0;
    adder_a      = r_pc;
    adder_b      = PC_STEP;
    pc_valid     = 1'b1;
    busy         = 1'b0;
    flush        = 1'b0;
    case (r_state)
      FETCH: begin
        // Branch is older than a concurrent jump, so it wins; any redirect
        // overrides stall.
        if (br_valid && br_taken) begin
          flush        = 1'b1;
          w_capture    = 1'b1;
          w_state_next = BR_CALC;
        end else if (jmp_valid) begin
          flush     = 1'b1;
          w_pc_next = {r_pc[31:28], jmp_target, 2'b00};
        end else if (!stall) begin
          w_pc_next  = w_sum_load;
          w_load_sum = 1'b1;
        end
      end
      BR_CALC: begin
        // Adder reassigned to the branch target; this cycle is a bubble.
        adder_a      = r_br_base;
        adder_b      = r_br_offset_sh;
        pc_valid     = 1'b0;
        busy         = 1'b1;
        w_pc_next    = w_sum_load;
        w_load_sum   = 1'b1;
        w_state_next = FETCH;
      end
      default: begin
        w_state_next = FETCH;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= FETCH;
    else       r_state <= w_state_next;
  end

  // Program counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_pc <= RESET_PC;
    else       r_pc <= w_pc_next;
  end

  // Captured branch operands, held for the BR_CALC cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_br_base      <= 32'd0;
      r_br_offset_sh <= 32'd0;
    end else if (w_capture) begin
      r_br_base      <= br_base;
      r_br_offset_sh <= br_offset << 2;
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  logic r_addr_err;
  logic w_misalign;

  // A misaligned reset vector is reported the cycle after reset releases.
  assign w_misalign = (w_load_sum && (adder_sum[1:0] != 2'b00)) ||
                      (RESET_VECTOR[1:0] != 2'b00);

  // Sticky misalignment flag, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_addr_err <= 1'b0;
    else       r_addr_err <= r_addr_err | w_misalign;
  end

  assign addr_err = r_addr_err;
`else
  assign addr_err = 1'b0;
`endif

  assign pc = r_pc;

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Owns the fetch-stage program counter and decides the next PC each cycle.
- Schedules the single shared 32-bit PC adder (ALU hardwired to add) between two uses: sequential increment (PC+4) and branch-target computation (base + offset<<2).
- A taken branch therefore costs one extra bubble cycle while the adder is reassigned.
- Jumps bypass the adder. Sits between the hazard unit and branch resolution logic on one side and instruction memory on the other.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
- PC_STEP, 32'd4, increment applied in sequential fetch.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  hazard unit hold request; freezes PC in FETCH.
- br_valid  in  1  branch resolved this cycle.
- br_taken  in  1  resolved branch is taken; qualified by br_valid.
- br_base  in  32  PC+4 of the branch instruction.
- br_offset  in  32  sign-extended word offset (not yet shifted).
- jmp_valid  in  1  jump resolved this cycle.
- jmp_target  in  26  J-type instr_index field.
- adder_a  out  32  operand A to shared adder.
- adder_b  out  32  operand B to shared adder.
- adder_sum  in  32  result from shared adder (combinational).
- pc  out  32  current fetch address.
- pc_valid  out  1  pc is a real fetch (0 = bubble).
- flush  out  1  kill younger in-flight instructions.
- busy  out  1  high in BR_CALC.
- addr_err  out  1  misaligned target detected (see Optional Feature).

Behaviour:
- State register: FETCH (00), BR_CALC (01). All state, pc and captured branch registers are cleared asynchronously on reset.
- Reset values:
  - pc = RESET_VECTOR, state = FETCH.
  - pc_valid = 1, flush = 0, busy = 0, addr_err = 0.
  - adder_a = RESET_VECTOR, adder_b = PC_STEP.
- FETCH:
  - adder_a = pc, adder_b = PC_STEP, pc_valid = 1, busy = 0.
  - Priority, highest first: taken branch (br_valid & br_taken), jump (jmp_valid), stall, sequential.
  - Taken branch:
    - flush = 1 this cycle (combinational).
    - Capture br_base and br_offset.
    - Next state BR_CALC; pc unchanged.
  - Jump:
    - flush = 1.
    - pc <= {pc[31:28], jmp_target, 2'b00}; stay FETCH.
  - Stall: pc holds, flush = 0.
  - Otherwise: pc <= adder_sum.
  - A not-taken branch (br_valid & !br_taken) has no effect.
  - Taken branch and jump in the same cycle: the branch wins, because it is the older instruction, and the jump is dropped.
  - Redirect with stall in the same cycle: the redirect wins and stall is ignored.
- BR_CALC (exactly one cycle):
  - adder_a = captured base, adder_b = captured offset << 2 (low two bits zero, upper bits shifted out).
  - pc_valid = 0, busy = 1, flush = 0.
  - pc <= adder_sum; next state FETCH.
  - stall, br_valid and jmp_valid are ignored in this state.
- Arithmetic: all 32-bit, wrap-around modulo 2^32, no overflow signalling (0xFFFF_FFFC + 4 = 0).
- Redirect latency:
  - Jump: new pc visible 1 cycle after acceptance.
  - Taken branch: new pc visible 2 cycles after acceptance, with 1 bubble.
- Reset asserted mid-BR_CALC: the captured branch is discarded and the block returns to FETCH at RESET_VECTOR.
- Outputs are combinational from state and registers. The only combinational input→output paths are flush (from br_*, jmp_valid) and pc (none).

Optional Feature:
- Macro: PC_ALIGN_CHECK_EN.
- Defined:
  - On any pc load whose low two bits are nonzero (branch sum, or reset vector), addr_err goes high the following cycle.
  - addr_err stays high (sticky) until reset.
  - pc is loaded with bits [1:0] forced to 00.
- Undefined:
  - addr_err is tied 0.
  - pc is loaded unmodified.
  - No alignment logic is synthesised.

Test Plan:
1. Release reset, no requests for 4 cycles → pc = 0x0, 0x4, 0x8, 0xC. adder_a tracks pc, adder_b = 4, pc_valid = 1 throughout.
2. stall = 1 for 2 cycles at pc = 0x8 → pc stays 0x8 for both cycles, then 0xC one cycle after stall drops. flush = 0.
3. At pc = 0x10, br_valid = br_taken = 1, br_base = 0x0C, br_offset = 0xFFFF_FFFE:
   - flush = 1 in the request cycle.
   - Next cycle: busy = 1, pc_valid = 0, adder_a = 0x0C, adder_b = 0xFFFF_FFF8.
   - Following cycle: pc = 0x04, pc_valid = 1.
4. At pc = 0x1000_0020, jmp_valid = 1, jmp_target = 0x040 → flush = 1; next cycle pc = 0x1000_0100, no bubble.
5. Same cycle as test 3, also assert jmp_valid and stall → the branch path of test 3 is taken; jump and stall have no effect.
6. Assert reset during BR_CALC → pc = RESET_VECTOR immediately, busy = 0, pc_valid = 1. After release, sequential fetch resumes from 0x0.
   - With PC_ALIGN_CHECK_EN defined, a branch giving sum 0x6 → pc = 0x4 and addr_err = 1, sticky until reset.
